instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Control unit that sequences the processor from the 20-bit instruction RAM.
- Drives the 7-bit PC into the RAM, accounts for the RAM's one-cycle registered read, and latches the instruction.
- Splits the instruction into opcode[19:16], addr/imm[15:4] and reg[3:0], then issues it to the datapath.
- Stalls on multi-cycle ops (WRITE, LOAD, MUL) until the datapath reports completion. Handles JMP and END.

Parameters:
- PC_W, 7, program counter width.
- PROG_DEPTH, 50, number of valid instruction words. Last valid address is PROG_DEPTH-1.
- INSTR_W, 20, instruction width.
- TIMEOUT_CYCLES, 255, watchdog limit. Used only when SEQ_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE and begins fetching at PC 0.
- PC  out  PC_W  instruction address to the RAM.
- instr_in  in  INSTR_W  RAM read data, valid the cycle after PC is presented.
- opcode  out  4  latched instr[19:16].
- operand  out  12  latched instr[15:4].
- reg_sel  out  4  latched instr[3:0].
- issue  out  1  one-cycle pulse; opcode/operand/reg_sel are valid.
- exec_done  in  1  datapath completion for multi-cycle ops.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- error  out  1  sticky fault flag, cleared only by reset.

Behaviour:
- Opcodes (ISA package):
  - 0000 NOP, 0001 JMP, 0010 RST, 0011 WRITE, 0100 LOADI.
  - 0101 MUL, 0110 LOAD, 0111 MV, 1111 END.
  - 1000–1110 are illegal.
- Multi-cycle class: WRITE, LOAD, MUL. Every other legal opcode is single-cycle.
- Reset (async, rst_n=0): state=IDLE; PC=0; opcode, operand, reg_sel=0; issue, busy, halted, error=0.
- Per-state actions and transitions:
  - IDLE: hold PC=0. start=1 → FETCH.
  - FETCH: PC stable; RAM registers the word at end of cycle → LATCH.
  - LATCH: capture instr_in into the instruction register → ISSUE.
  - ISSUE: issue=1 for exactly this cycle; fields are stable from this cycle until the next LATCH.
    - Multi-cycle op → WAIT_EXEC.
    - END → HALT.
    - Illegal opcode → set error, → HALT.
    - JMP → PC=operand[PC_W-1:0], → FETCH.
    - Otherwise → advance PC, → FETCH.
  - WAIT_EXEC: stay until exec_done=1, then advance PC, → FETCH.
  - HALT: terminal. Only reset leaves it; start is ignored.
- exec_done outside WAIT_EXEC is ignored. exec_done in the same cycle as ISSUE is not sampled; only WAIT_EXEC samples it.
- Advance PC:
  - PC < PROG_DEPTH-1 → PC+1.
  - PC == PROG_DEPTH-1 (running off the program end) → set error, → HALT, PC unchanged.
- JMP target ≥ PROG_DEPTH → set error, → HALT, PC unchanged.
- Latency:
  - Single-cycle instruction: 3 cycles (FETCH, LATCH, ISSUE); the next issue comes 3 cycles later.
  - Multi-cycle instruction: 3 + N cycles, where N is the number of WAIT_EXEC cycles including the one where exec_done=1.
- Reset mid-operation: immediate return to reset values. The in-flight instruction is dropped and no issue is emitted.
- The PC output is registered; no combinational path from instr_in to PC.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit-min counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry to WAIT_EXEC and counts each cycle exec_done=0.
  - When it reaches TIMEOUT_CYCLES: set error, → HALT.
  - exec_done=1 on the limit cycle wins; normal completion, no error.
- Undefined: no counter; WAIT_EXEC waits indefinitely.

Decomposition:
- Shared package isa_pkg holds:
  - opcode localparams (OP_NOP … OP_END);
  - field bit positions (OPC_HI=19, OPC_LO=16, OPR_HI=15, OPR_LO=4, REG_HI=3, REG_LO=0);
  - state encoding enum (IDLE, FETCH, LATCH, ISSUE, WAIT_EXEC, HALT);
  - function is_multicycle(opcode).
- One sub-module, instr_decode: combinational opcode classification (multicycle, jump, end, illegal). The FSM and PC stay in instr_sequencer.

Test Plan:
- Reset then start=1, program {LOADI, MV, END}, exec_done=0 →
  - issue pulses at cycles 3, 6, 9 (cycle 1 = first FETCH), with PC=0, 1, 2;
  - halted=1 after the END issue; error=0.
- MUL at PC 0, exec_done asserted 4 cycles after issue → PC stays 0 through WAIT_EXEC, next FETCH uses PC=1, exactly one issue for the MUL.
- JMP operand=12'h00A at PC 3 → next fetch PC=10. JMP operand=12'h040 (64 ≥ 50) → error=1, halted=1, PC stays 3.
- Opcode 4'b1010 at PC 0 → issue pulses once, then error=1 and halted=1. A subsequent start=1 has no effect.
- rst_n pulsed low during WAIT_EXEC → all outputs 0 asynchronously. After release, start=1 refetches PC=0.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=255: LOAD with exec_done held 0 → error=1 and halted=1 exactly 255 cycles after WAIT_EXEC entry. Repeat with exec_done=1 on cycle 255 → no error, PC advances.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA package for the instruction sequencer.
// Holds the opcode encodings, the field positions inside a 20-bit instruction,
// the sequencer state encoding, and the multi-cycle classification helper.
package isa_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_JMP   = 4'h1;
   localparam logic [3:0] OP_RST   = 4'h2;
   localparam logic [3:0] OP_WRITE = 4'h3;
   localparam logic [3:0] OP_LOADI = 4'h4;
   localparam logic [3:0] OP_MUL   = 4'h5;
   localparam logic [3:0] OP_LOAD  = 4'h6;
   localparam logic [3:0] OP_MV    = 4'h7;
   localparam logic [3:0] OP_END   = 4'hF;

   localparam int unsigned OPC_HI = 19;
   localparam int unsigned OPC_LO = 16;
   localparam int unsigned OPR_HI = 15;
   localparam int unsigned OPR_LO = 4;
   localparam int unsigned REG_HI = 3;
   localparam int unsigned REG_LO = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      ISSUE,
      WAIT_EXEC,
      HALT
   } seq_state_t;

   function automatic logic is_multicycle(input logic [3:0] opc);
      return (opc == OP_WRITE) || (opc == OP_LOAD) || (opc == OP_MUL);
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction RAM and datapath bus of the sequencer.
//   PC        : instruction address to the RAM (sequencer -> RAM)
//   instr_in  : registered RAM read data, valid the cycle after PC
//   opcode/operand/reg_sel : latched instruction fields (sequencer -> datapath)
//   issue     : one-cycle pulse, fields valid
//   exec_done : datapath completion for multi-cycle ops
// master = sequencer side, slave = RAM/datapath side.
interface instr_sequencer_if #(
   parameter int unsigned PC_W    = 7,
   parameter int unsigned INSTR_W = 20
);
   logic [PC_W-1:0]    PC;
   logic [INSTR_W-1:0] instr_in;
   logic [3:0]         opcode;
   logic [11:0]        operand;
   logic [3:0]         reg_sel;
   logic               issue;
   logic               exec_done;

   modport master (
      output PC, opcode, operand, reg_sel, issue,
      input  instr_in, exec_done
   );

   modport slave (
      input  PC, opcode, operand, reg_sel, issue,
      output instr_in, exec_done
   );
endinterface

// File: rtl/instr_decode.sv
// Combinational opcode classifier for the sequencer.
//   opcode     in  : latched opcode field
//   multicycle out : WRITE, LOAD or MUL (waits for exec_done)
//   is_jump    out : JMP
//   is_end     out : END
//   illegal    out : 1000..1110
module instr_decode
   import isa_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       multicycle,
   output logic       is_jump,
   output logic       is_end,
   output logic       illegal
);

   always_comb begin
      multicycle = is_multicycle(opcode);
      is_jump    = (opcode == OP_JMP);
      is_end     = (opcode == OP_END);
      illegal    = opcode[3] && (opcode != OP_END);
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from a registered-read instruction RAM,
// latches and splits the word, issues it to the datapath, stalls on
// multi-cycle ops, and handles JMP / END / faults.
// Ports:
//   clk, rst_n (async active-low), start (level, leaves IDLE)
//   bus    : instr_sequencer_if.master (PC, instr_in, opcode, operand,
//            reg_sel, issue, exec_done)
//   busy   : high outside IDLE and HALT
//   halted : high in HALT
//   error  : sticky fault flag, cleared only by reset
// Optional macro SEQ_TIMEOUT_EN: WAIT_EXEC watchdog of TIMEOUT_CYCLES cycles.
module instr_sequencer
   import isa_pkg::*;
#(
   parameter int unsigned PC_W           = 7,
   parameter int unsigned PROG_DEPTH     = 50,
   parameter int unsigned INSTR_W        = 20,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   instr_sequencer_if.master   bus,
   output logic                busy,
   output logic                halted,
   output logic                error
);

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [3:0]      opc_q;
   logic [11:0]     opr_q;
   logic [3:0]      reg_q;
   logic            err_q, err_set;

   logic dec_multi, dec_jump, dec_end, dec_illegal;

   instr_decode u_decode (
      .opcode     (opc_q),
      .multicycle (dec_multi),
      .is_jump    (dec_jump),
      .is_end     (dec_end),
      .illegal    (dec_illegal)
   );

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TO_W   = (TO_RAW < 8) ? 8 : TO_RAW;
   logic [TO_W-1:0] to_cnt_q;

   // Cleared while issuing (i.e. on entry to WAIT_EXEC), counts idle wait cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else if (state_q == ISSUE) begin
         to_cnt_q <= '0;
      end else if (state_q == WAIT_EXEC && !bus.exec_done) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_set = 1'b0;
      case (state_q)
         IDLE: begin
            pc_d = '0;
            if (start) state_d = FETCH;
         end
         FETCH: state_d = LATCH;
         LATCH: state_d = ISSUE;
         ISSUE: begin
            if (dec_illegal) begin
               err_set = 1'b1;
               state_d = HALT;
            end else if (dec_end) begin
               state_d = HALT;
            end else if (dec_multi) begin
               state_d = WAIT_EXEC;
            end else if (dec_jump) begin
               // Range check uses the full operand so high bits cannot alias into range.
               if (32'(opr_q) >= PROG_DEPTH) begin
                  err_set = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d    = opr_q[PC_W-1:0];
                  state_d = FETCH;
               end
            end else if (pc_q == LAST_PC) begin
               err_set = 1'b1;
               state_d = HALT;
            end else begin
               pc_d    = pc_q + 1'b1;
               state_d = FETCH;
            end
         end
         WAIT_EXEC: begin
            if (bus.exec_done) begin
               if (pc_q == LAST_PC) begin
                  err_set = 1'b1;
                  state_d = HALT;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = FETCH;
               end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               err_set = 1'b1;
               state_d = HALT;
            end
`endif
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (err_set) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opc_q <= '0;
         opr_q <= '0;
         reg_q <= '0;
      end else if (state_q == LATCH) begin
         opc_q <= bus.instr_in[OPC_HI:OPC_LO];
         opr_q <= bus.instr_in[OPR_HI:OPR_LO];
         reg_q <= bus.instr_in[REG_HI:REG_LO];
      end
   end

   assign bus.PC      = pc_q;
   assign bus.opcode  = opc_q;
   assign bus.operand = opr_q;
   assign bus.reg_sel = reg_q;
   assign bus.issue   = (state_q == ISSUE);
   assign busy        = (state_q != IDLE) && (state_q != HALT);
   assign halted      = (state_q == HALT);
   assign error       = err_q;

endmodule
